// File: rtl/spi_pkg.sv
// Shared SPI constants and types used by the responder and the host-side master.
package spi_pkg;
   localparam int SPI_DATA_W = 8;
   localparam logic [SPI_DATA_W-1:0] SPI_IDLE_WORD = 8'hFF;
   localparam int SPI_CNT_W = $clog2(SPI_DATA_W);
   localparam bit SPI_CPOL = 1'b1;
   localparam bit SPI_CPHA = 1'b1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;
endpackage

// File: rtl/spi_slave_if.sv
// Byte-stream side of the SPI responder: RX valid/ready stream and TX holding register.
interface spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
);
   logic [DATA_W-1:0] rx_data_o;
   logic              rx_valid_o;
   logic              rx_ready_i;
   logic              rx_overrun_o;
   logic [DATA_W-1:0] tx_data_i;
   logic              tx_valid_i;
   logic              tx_ready_o;

   modport slave (
      output rx_data_o, rx_valid_o, rx_overrun_o, tx_ready_o,
      input  rx_ready_i, tx_data_i, tx_valid_i
   );

   modport master (
      input  rx_data_o, rx_valid_o, rx_overrun_o, tx_ready_o,
      output rx_ready_i, tx_data_i, tx_valid_i
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus history flop; reports synchronized level and edges.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic              hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {STAGES{RST_VAL}};
         hist <= RST_VAL;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         hist <= sync[STAGES-1];
      end
   end

   assign level = sync[STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 responder oversampled on sys_clk, bridging SPI pins to a byte stream.
module spi_slave
   import spi_pkg::*;
#(
   parameter int                DATA_W      = SPI_DATA_W,
   parameter logic [DATA_W-1:0] IDLE_WORD   = SPI_IDLE_WORD,
   parameter int                SYNC_STAGES = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             spi_clk_i,
   input  logic             spi_mosi_i,
   input  logic             spi_cs_i,
   output logic             spi_miso_o,
   output logic             busy_o,
   spi_slave_if.slave       strm
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [0:0] S_IDLE   = IDLE;
   localparam logic [0:0] S_ACTIVE = ACTIVE;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic cs_level, cs_rise, cs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
      .clk(sys_clk), .rst(sys_rst), .din(spi_clk_i),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(sys_clk), .rst(sys_rst), .din(spi_mosi_i),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );
   // CS resets low so a select held low across reset never yields a fall.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
      .clk(sys_clk), .rst(sys_rst), .din(spi_cs_i),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall, cs_level};

   logic [0:0]        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_word;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_overrun;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic              miso;

   assign rx_word = {rx_shift[DATA_W-2:0], mosi_level};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         tx_shift   <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         miso       <= 1'b1;
      end else begin
         rx_overrun <= 1'b0;
         if (rx_valid && strm.rx_ready_i)
            rx_valid <= 1'b0;
         // Write needs an empty holding register, load needs a full one,
         // so a same-cycle write never feeds the bit-0 load.
         if (strm.tx_valid_i && !hold_full) begin
            hold_data <= strm.tx_data_i;
            hold_full <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               miso    <= 1'b1;
               if (cs_fall)
                  state <= S_ACTIVE;
            end
            default: begin
               if (cs_rise) begin
                  state   <= S_IDLE;
                  bit_cnt <= '0;
                  miso    <= 1'b1;
               end else begin
                  if (sclk_fall) begin
                     if (bit_cnt == '0) begin
                        if (hold_full) begin
                           miso      <= hold_data[DATA_W-1];
                           tx_shift  <= {hold_data[DATA_W-2:0], 1'b0};
                           hold_full <= 1'b0;
                        end else begin
                           miso     <= IDLE_WORD[DATA_W-1];
                           tx_shift <= {IDLE_WORD[DATA_W-2:0], 1'b0};
                        end
                     end else begin
                        miso     <= tx_shift[DATA_W-1];
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                     end
                  end
                  if (sclk_rise) begin
                     rx_shift <= rx_word;
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (!rx_valid || strm.rx_ready_i) begin
                           rx_data  <= rx_word;
                           rx_valid <= 1'b1;
                        end else begin
                           rx_overrun <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign spi_miso_o        = miso;
   assign busy_o            = (state == S_ACTIVE);
   assign strm.rx_data_o    = rx_data;
   assign strm.rx_valid_o   = rx_valid;
   assign strm.rx_overrun_o = rx_overrun;
   assign strm.tx_ready_o   = ~hold_full;
endmodule
